sw_debounce5: RTL and testbench
===============================

Name: sw_debounce5

Overview:
- Input conditioning stage that sits directly upstream of the 5-input encoder/decoder logic and drives its in[4:0] bus.
- Synchronises five raw board switches into clk and debounces each bit independently.
- Presents a stable 5-bit vector plus one-cycle rise/fall/change strobes for later stages.
- A start-up FSM holds the outputs quiet until the synchroniser and counters have settled after reset.

Parameters:
WIDTH, 5, number of switch bits (the downstream logic consumes exactly 5)
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised bit must differ from its debounced value before it is accepted; legal range >= 2
CNT_W, $clog2(DEBOUNCE_CYCLES), per-bit counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sw_raw  input  WIDTH  raw, asynchronous, bouncing switch levels
sw_db  output  WIDTH  debounced, registered switch vector; drives the encoder/decoder in[4:0]
sw_rise  output  WIDTH  per-bit one-cycle pulse when sw_db bit goes 0->1
sw_fall  output  WIDTH  per-bit one-cycle pulse when sw_db bit goes 1->0
changed  output  1  one-cycle pulse, OR of sw_rise|sw_fall
ready  output  1  high once start-up has completed (RUN state)

Behaviour:
- Reset (rst_n=0, asynchronous): sync stages=0, counters=0, sw_db=0, sw_rise=0, sw_fall=0, changed=0, ready=0, FSM=INIT, init counter=0. Release is taken on the next rising edge.
- Synchroniser: two flops per bit (s1<=sw_raw, s2<=s1). No logic between the stages.
- Per-bit debounce (RUN only), evaluated each edge:
  - If s2[i]==sw_db[i]: cnt[i]<=0, meaning any bounce back restarts the count.
  - If s2[i]!=sw_db[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
  - If s2[i]!=sw_db[i] and cnt[i]==DEBOUNCE_CYCLES-1: sw_db[i]<=s2[i], cnt[i]<=0, and a rise or fall pulse is registered on the same edge.
- Latency: sw_db[i] changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw level. Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output change.
- Pulses: sw_rise, sw_fall and changed are registered and high for exactly one cycle, aligned with the cycle in which the new sw_db value is first visible. A bit cannot re-toggle in fewer than DEBOUNCE_CYCLES cycles, so pulses never merge.
- Simultaneous events: bits are fully independent. Several bits may pulse in the same cycle; changed is a single 1-cycle pulse in that case.
- FSM:
  - INIT: counts DEBOUNCE_CYCLES+2 cycles after reset release. sw_db is held 0, pulses are suppressed, and per-bit counters are held at 0.
  - On the final INIT cycle: sw_db<=s2 (bulk load, no pulses), ready<=1, next state RUN.
  - RUN: normal debounce. Terminal state; leaves only via reset.
- Reset mid-operation: all state clears immediately, including any in-flight counts; outputs return to reset values and INIT restarts.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
1. Reset release with sw_raw=5'b10110 held -> ready=0 and sw_db=0 for 5 edges; on the 6th edge ready=1, sw_db=5'b10110, sw_rise=sw_fall=0, changed=0.
2. In RUN with sw_db=0, set sw_raw[2]=1 and hold -> sw_db=5'b00100 after the 6th edge; sw_rise=5'b00100 and changed=1 for exactly one cycle.
3. Bounce: in RUN, sw_raw[0] toggles 0,1,0,1 every 2 cycles, then holds 1 -> no change in sw_db during bouncing; sw_db[0]=1 six edges after the last 0->1 transition.
4. Glitch: sw_raw[4] high for 3 cycles, then low -> sw_db[4] stays 0, no sw_rise pulse, changed stays 0.
5. Simultaneous: from sw_db=5'b00011, sw_raw goes to 5'b11000 in one cycle -> after 6 edges sw_db=5'b11000, sw_rise=5'b11000, sw_fall=5'b00011, single-cycle changed=1.
6. Reset asserted 3 cycles into a pending count -> outputs 0 and ready=0 immediately, asynchronously; after release, INIT repeats and no pulse is ever emitted for the aborted count.

Source files
------------

// File: rtl/sw_debounce5.sv
// Switch conditioning for the 5-input encoder/decoder: 2-flop sync, per-bit
// debounce with rise/fall/change strobes, and a start-up hold until settled.
module sw_debounce5 #(
   parameter int WIDTH           = 5,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed,
   output logic             ready
);

   localparam int              INIT_W    = $clog2(DEBOUNCE_CYCLES + 2);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [WIDTH-1:0]            s1, s2;
   logic [WIDTH-1:0][CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0]            db_nxt, rise_nxt, fall_nxt;
   logic [INIT_W-1:0]           init_cnt;
   logic [0:0]                  state;

   // Any sample equal to the current debounced level restarts that bit's count.
   always_comb begin
      cnt_nxt  = cnt;
      db_nxt   = sw_db;
      rise_nxt = '0;
      fall_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (s2[i] == sw_db[i]) begin
            cnt_nxt[i] = '0;
         end else if (cnt[i] == CNT_MAX) begin
            cnt_nxt[i]  = '0;
            db_nxt[i]   = s2[i];
            rise_nxt[i] = s2[i];
            fall_nxt[i] = ~s2[i];
         end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         sw_db    <= '0;
         sw_rise  <= '0;
         sw_fall  <= '0;
         changed  <= 1'b0;
         ready    <= 1'b0;
         init_cnt <= '0;
         state    <= ST_INIT;
      end else begin
         case (state)
            ST_INIT: begin
               cnt     <= '0;
               sw_rise <= '0;
               sw_fall <= '0;
               changed <= 1'b0;
               // Bulk-load the settled sync output so start-up levels make no pulses.
               if (init_cnt == INIT_LAST) begin
                  sw_db <= s2;
                  ready <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  sw_db    <= '0;
                  init_cnt <= init_cnt + INIT_W'(1);
               end
            end
            default: begin
               cnt     <= cnt_nxt;
               sw_db   <= db_nxt;
               sw_rise <= rise_nxt;
               sw_fall <= fall_nxt;
               changed <= |(rise_nxt | fall_nxt);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sw_debounce5.sv
// Directed bench for sw_debounce5 with DEBOUNCE_CYCLES=4 (6-edge latency).
module tb_sw_debounce5;

   logic       clk;
   logic       rst_n;
   logic [4:0] sw_raw;
   logic [4:0] sw_db, sw_rise, sw_fall;
   logic       changed, ready;

   int checks = 0;
   int errors = 0;

   sw_debounce5 #(.WIDTH(5), .DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall),
      .changed (changed),
      .ready   (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then park on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Expect sw_db to hold 'old' for 5 edges and become 'nw' with the given strobes on edge 6.
   task automatic expect_change(input string tag, input logic [4:0] old, input logic [4:0] nw,
                                input logic [4:0] rise, input logic [4:0] fall);
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk({tag, "_hold_db"}, sw_db, old);
         chk({tag, "_hold_chg"}, changed, 1'b0);
      end
      step(1);
      chk({tag, "_db"}, sw_db, nw);
      chk({tag, "_rise"}, sw_rise, rise);
      chk({tag, "_fall"}, sw_fall, fall);
      chk({tag, "_chg"}, changed, |(rise | fall));
      step(1);
      chk({tag, "_rise_clr"}, sw_rise, 5'b0);
      chk({tag, "_fall_clr"}, sw_fall, 5'b0);
      chk({tag, "_chg_clr"}, changed, 1'b0);
   endtask

   task automatic expect_init(input string tag, input logic [4:0] lvl);
      for (int k = 1; k <= 5; k++) begin
         step(1);
         chk({tag, "_rdy0"}, ready, 1'b0);
         chk({tag, "_db0"}, sw_db, 5'b0);
         chk({tag, "_chg0"}, changed, 1'b0);
      end
      step(1);
      chk({tag, "_rdy1"}, ready, 1'b1);
      chk({tag, "_load"}, sw_db, lvl);
      chk({tag, "_rise0"}, sw_rise, 5'b0);
      chk({tag, "_fall0"}, sw_fall, 5'b0);
      chk({tag, "_chg_load"}, changed, 1'b0);
   endtask

   initial begin
      rst_n  = 1'b0;
      sw_raw = 5'b10110;
      step(3);
      chk("rst_db", sw_db, 5'b0);
      chk("rst_rdy", ready, 1'b0);
      chk("rst_chg", changed, 1'b0);
      chk("rst_rise", sw_rise, 5'b0);

      // 1: start-up with a non-zero level held
      rst_n = 1'b1;
      expect_init("init", 5'b10110);

      // return to all-zero, then 2: single rising bit
      sw_raw = 5'b00000;
      expect_change("to0", 5'b10110, 5'b00000, 5'b00000, 5'b10110);
      sw_raw = 5'b00100;
      expect_change("rise2", 5'b00000, 5'b00100, 5'b00100, 5'b00000);

      // 3: bounce on bit 0 (0,0,1,1,0,0) then hold 1
      for (int k = 0; k < 6; k++) begin
         sw_raw = (k == 2 || k == 3) ? 5'b00101 : 5'b00100;
         step(1);
         chk("bounce_db", sw_db, 5'b00100);
         chk("bounce_chg", changed, 1'b0);
      end
      sw_raw = 5'b00101;
      expect_change("bounce", 5'b00100, 5'b00101, 5'b00001, 5'b00000);

      // 4: 3-cycle glitch on bit 4
      sw_raw = 5'b10101;
      step(3);
      sw_raw = 5'b00101;
      for (int k = 0; k < 8; k++) begin
         chk("glitch_db", sw_db, 5'b00101);
         chk("glitch_rise", sw_rise, 5'b0);
         chk("glitch_chg", changed, 1'b0);
         step(1);
      end

      // 5: simultaneous rise and fall
      sw_raw = 5'b00011;
      expect_change("pre5", 5'b00101, 5'b00011, 5'b00010, 5'b00100);
      sw_raw = 5'b11000;
      expect_change("simul", 5'b00011, 5'b11000, 5'b11000, 5'b00011);

      // 6: reset mid-count, asynchronously
      sw_raw = 5'b11100;
      step(3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_db", sw_db, 5'b0);
      chk("arst_rdy", ready, 1'b0);
      chk("arst_chg", changed, 1'b0);
      step(2);
      rst_n = 1'b1;
      expect_init("reinit", 5'b11100);
      for (int k = 0; k < 6; k++) begin
         step(1);
         chk("post_db", sw_db, 5'b11100);
         chk("post_chg", changed, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
